// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions used by the PC sequencer and its reg_arithmetic neighbour.
package pc_sequencer_pkg;

  // Program counter width, common to the sequencer and reg_arithmetic.
  localparam int PC_W = 8;

  // Run/halt control states of the sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, run/halt control and the retired-instruction
// count, and steers reg_arithmetic to compute the next PC.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] START_ADDR = 8'h00,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic             is_halt,
  input  logic             is_jizr,
  input  logic             is_jnzr,
  input  logic [2:0]       br_off,
  input  logic             zero_flag,
  output logic [PC_W-1:0]  arith_x,
  output logic             arith_incr,
  output logic             arith_decr,
  output logic             arith_jizr,
  output logic             arith_jnzr,
  output logic [2:0]       arith_v,
  input  logic [PC_W-1:0]  arith_res,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  pc_state_t        state, state_next;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] retired_next;
  logic             take_z, take_nz, retire;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // One-hot operation select for reg_arithmetic; jizr wins when both branch kinds are set.
  always_comb begin
    take_z     = is_jizr & zero_flag;
    take_nz    = is_jnzr & ~zero_flag & ~is_jizr;
    arith_x    = pc;
    arith_jizr = take_z;
    arith_jnzr = take_nz;
    arith_incr = ~(take_z | take_nz);
    arith_decr = 1'b0;
    arith_v    = (take_z | take_nz) ? br_off : 3'b000;
  end

  // Next-state logic: only a retiring instruction moves the PC or the retired count.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    retired_next = retired;
    retire       = (state == RUN) & instr_valid & ~stall;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          pc_next      = START_ADDR;
          retired_next = '0;
        end
      end
      RUN: begin
        if (retire) begin
          retired_next = (retired == CNT_MAX) ? retired : retired + CNT_ONE;
          if (is_halt) begin
            state_next = HALT;
          end else begin
            pc_next = arith_res;
          end
        end
      end
      HALT: begin
        if (start) begin
          state_next   = RUN;
          pc_next      = START_ADDR;
          retired_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, PC, counter and status flags all update on the rising edge; reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= START_ADDR;
      retired <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      retired <= retired_next;
      running <= (state_next == RUN);
      done    <= (state_next == HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural reg_arithmetic beside it.
module tb_pc_sequencer;

  localparam int TB_CNT_W = 5;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset, start, instr_valid, stall, is_halt, is_jizr, is_jnzr, zero_flag;
  logic [2:0]          br_off;
  logic [7:0]          arith_x, arith_res, pc;
  logic                arith_incr, arith_decr, arith_jizr, arith_jnzr;
  logic [2:0]          arith_v;
  logic                running, done;
  logic [TB_CNT_W-1:0] retired;

  typedef struct packed {
    logic [7:0] x;
    logic       incr, decr, jizr, jnzr;
    logic [2:0] v;
  } arith_exp_t;

  typedef struct packed {
    logic [7:0]          pc;
    logic                running, done;
    logic [TB_CNT_W-1:0] retired;
  } state_exp_t;

  arith_exp_t arith_q[$];
  state_exp_t state_q[$];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: mode 0 idle, 1 run, 2 halted
  int m_mode = 0;
  int m_pc   = 0;
  int m_ret  = 0;
  bit m_known = 0;

  pc_sequencer #(.START_ADDR(8'h00), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid), .stall(stall),
    .is_halt(is_halt), .is_jizr(is_jizr), .is_jnzr(is_jnzr), .br_off(br_off),
    .zero_flag(zero_flag), .arith_x(arith_x), .arith_incr(arith_incr),
    .arith_decr(arith_decr), .arith_jizr(arith_jizr), .arith_jnzr(arith_jnzr),
    .arith_v(arith_v), .arith_res(arith_res), .pc(pc), .running(running),
    .done(done), .retired(retired)
  );

  // Behavioural reg_arithmetic: x+1, or x+2*v for a taken branch, modulo 256
  assign arith_res = (arith_jizr | arith_jnzr) ? arith_x + {4'b0000, arith_v, 1'b0} :
                     arith_incr ? arith_x + 8'd1 : arith_x;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and pushes the model's expected responses.
  task automatic applyStimulus(input bit rst, input bit st, input bit vl, input bit stl,
                               input bit hl, input bit jz, input bit jnz,
                               input bit [2:0] off, input bit zf);
    bit tz, tnz;
    arith_exp_t ae;
    state_exp_t se;
    @(negedge clk);
    reset = rst; start = st; instr_valid = vl; stall = stl; is_halt = hl;
    is_jizr = jz; is_jnzr = jnz; br_off = off; zero_flag = zf;
    tz  = jz && zf;
    tnz = jnz && !zf && !jz;
    if (m_known) begin
      ae.x    = 8'(m_pc);
      ae.incr = !(tz || tnz);
      ae.decr = 1'b0;
      ae.jizr = tz;
      ae.jnzr = tnz;
      ae.v    = (tz || tnz) ? off : 3'd0;
      arith_q.push_back(ae);
    end
    if (rst) begin
      m_known = 1; m_mode = 0; m_pc = 0; m_ret = 0;
    end else if (m_known) begin
      if (m_mode == 1) begin
        if (vl && !stl) begin
          if (m_ret < CNT_MAX) m_ret = m_ret + 1;
          if (hl) m_mode = 2;
          else    m_pc = (m_pc + ((tz || tnz) ? 2 * int'(off) : 1)) % 256;
        end
      end else if (st) begin
        m_mode = 1; m_pc = 0; m_ret = 0;
      end
    end
    if (m_known) begin
      se.pc      = 8'(m_pc);
      se.running = (m_mode == 1);
      se.done    = (m_mode == 2);
      se.retired = TB_CNT_W'(m_ret);
      state_q.push_back(se);
    end
  endtask

  task automatic doInstrs(input int n);
    repeat (n) applyStimulus(0, 0, 1, 0, 0, 0, 0, 3'd0, 0);
  endtask

  // Combinational arith outputs, compared mid-cycle after inputs settle
  initial begin
    arith_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (arith_q.size() > 0) begin
        e = arith_q.pop_front();
        checkOutput("arith_x", 32'(arith_x), 32'(e.x));
        checkOutput("arith_sel", {28'd0, arith_incr, arith_decr, arith_jizr, arith_jnzr},
                    {28'd0, e.incr, e.decr, e.jizr, e.jnzr});
        checkOutput("arith_v", 32'(arith_v), 32'(e.v));
      end
    end
  end

  // Registered outputs, compared just after each rising edge
  initial begin
    state_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        checkOutput("pc", 32'(pc), 32'(e.pc));
        checkOutput("running", 32'(running), 32'(e.running));
        checkOutput("done", 32'(done), 32'(e.done));
        checkOutput("retired", 32'(retired), 32'(e.retired));
      end
    end
  end

  initial begin
    reset = 1; start = 0; instr_valid = 0; stall = 0; is_halt = 0;
    is_jizr = 0; is_jnzr = 0; br_off = 0; zero_flag = 0;

    // Reset, start, four straight-line instructions
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 3'd0, 0);
    doInstrs(4);
    @(posedge clk); #1;
    checkOutput("const_pc_04", 32'(pc), 32'h04);
    checkOutput("const_retired_4", 32'(retired), 32'd4);

    // Branch on zero, taken and not taken
    doInstrs(12);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 3'd3, 1);
    @(posedge clk); #1;
    checkOutput("const_pc_jizr_taken", 32'(pc), 32'h16);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 3'd3, 0);
    @(posedge clk); #1;
    checkOutput("const_pc_jizr_not", 32'(pc), 32'h17);

    // Branch on nonzero, then wrap at FF
    doInstrs(9);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 3'd7, 0);
    @(posedge clk); #1;
    checkOutput("const_pc_jnzr", 32'(pc), 32'h2E);
    doInstrs(209);
    doInstrs(1);
    @(posedge clk); #1;
    checkOutput("const_pc_wrap", 32'(pc), 32'h00);
    checkOutput("const_retired_sat", 32'(retired), 32'(CNT_MAX));

    // Stall holds, stall beats halt
    doInstrs(5);
    repeat (3) applyStimulus(0, 0, 1, 1, 0, 0, 0, 3'd0, 0);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 3'd0, 0);
    @(posedge clk); #1;
    checkOutput("const_pc_stall", 32'(pc), 32'h05);
    checkOutput("const_run_stall_halt", 32'(running), 32'd1);

    // Halt, ignored instructions, restart
    doInstrs(4);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 3'd0, 0);
    @(posedge clk); #1;
    checkOutput("const_halt_done", 32'(done), 32'd1);
    checkOutput("const_halt_pc", 32'(pc), 32'h09);
    doInstrs(3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 3'd0, 0);
    @(posedge clk); #1;
    checkOutput("const_restart_ret", 32'(retired), 32'd0);

    // Reset in the middle of a run, then start together with reset
    doInstrs(51);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 3'd0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    @(posedge clk); #1;
    checkOutput("const_reset_run", 32'(running), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(199) == 0), ($urandom_range(19) == 0),
                    ($urandom_range(3) != 0), ($urandom_range(4) == 0),
                    ($urandom_range(29) == 0), ($urandom_range(3) == 0),
                    ($urandom_range(3) == 0), 3'($urandom_range(7)),
                    1'($urandom_range(1)));
    end

    @(posedge clk); #3;
    checkOutput("queues_drained", 32'(arith_q.size() + state_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
